// File: rtl/mux_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_arbiter_if
// Brief    : Request/data and grant/output bundle for the 4-lane mux arbiter.
// Revision : 1.0
// ============================================================================
interface mux_arbiter_if #(
    parameter int DATA_W = 8
);
    logic [3:0]          req;
    logic [4*DATA_W-1:0] a;
    logic [3:0]          grant;
    logic [1:0]          select_line;
    logic [DATA_W-1:0]   b;
    logic                valid;

    modport master (
        output req, a,
        input  grant, select_line, b, valid
    );

    modport slave (
        input  req, a,
        output grant, select_line, b, valid
    );
endinterface
`default_nettype wire

// File: rtl/mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_arbiter
// Brief    : 4-requester burst arbiter driving a registered shared 4:1 mux.
//            Define MUX_ARBITER_FIXED_PRIO_EN for lowest-index-wins priority.
// Revision : 1.0
// ============================================================================
module mux_arbiter #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    mux_arbiter_if.slave    bus
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]        r_state, w_state_nxt;
    logic [3:0]        r_grant, w_grant_nxt;
    logic [1:0]        r_sel,   w_sel_nxt;
    logic [DATA_W-1:0] r_b,     w_b_nxt;
    logic              r_valid, w_valid_nxt;
    logic [3:0]        r_cnt,   w_cnt_nxt;
    logic [1:0]        r_ptr,   w_ptr_nxt;

    logic [DATA_W-1:0] w_lane [4];
    logic [1:0]        w_winner;
    logic              w_any_req;
    logic              w_beat;
    logic              w_last;
    logic              w_release;
    logic [4:0]        w_cnt_inc;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane[gi] = bus.a[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign w_any_req = |bus.req;

    // Descending scan so the last hit is the first requester in search order.
    always_comb begin
        w_winner = 2'd0;
`ifdef MUX_ARBITER_FIXED_PRIO_EN
        for (int k = 3; k >= 0; k--) begin
            if (bus.req[k]) w_winner = 2'(k);
        end
`else
        for (int k = 3; k >= 0; k--) begin
            if (bus.req[r_ptr + 2'(k)]) w_winner = r_ptr + 2'(k);
        end
`endif
    end

    assign w_beat    = (r_state == S_BUSY) && bus.req[r_sel];
    assign w_cnt_inc = {1'b0, r_cnt} + 5'd1;
    assign w_last    = w_beat && (w_cnt_inc == 5'(BURST_LEN));
    assign w_release = (r_state == S_BUSY) && (!w_beat || w_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_sel   <= '0;
            r_b     <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_sel   <= w_sel_nxt;
            r_b     <= w_b_nxt;
            r_valid <= w_valid_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_state_nxt = S_BUSY;
            S_BUSY:  if (w_release) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_grant_nxt = r_grant;
        w_sel_nxt   = r_sel;
        w_b_nxt     = r_b;
        w_valid_nxt = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_grant_nxt = 4'b0001 << w_winner;
                    w_sel_nxt   = w_winner;
                    w_cnt_nxt   = '0;
                end else begin
                    w_grant_nxt = '0;
                end
            end
            S_BUSY: begin
                if (w_beat) begin
                    w_b_nxt     = w_lane[r_sel];
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = w_cnt_inc[3:0];
                end
                if (w_release) begin
                    w_grant_nxt = '0;
`ifdef MUX_ARBITER_FIXED_PRIO_EN
                    w_ptr_nxt   = '0;
`else
                    w_ptr_nxt   = r_sel + 2'd1;
`endif
                end
            end
            default: w_grant_nxt = '0;
        endcase
    end

    assign bus.grant       = r_grant;
    assign bus.select_line = r_sel;
    assign bus.b           = r_b;
    assign bus.valid       = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_arbiter
// Brief    : Self-checking bench: directed scenarios plus randomized traffic
//            compared every cycle against a transaction-level arbiter model.
// Revision : 1.0
// ============================================================================
module tb_mux_arbiter;

    localparam int DATA_W    = 8;
    localparam int BURST_LEN = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    mux_arbiter_if #(.DATA_W(DATA_W)) bus ();

    mux_arbiter #(
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Model: who owns the bus (-1 = nobody), beats taken, search start,
    // plus the values the outputs must show in the following cycle.
    typedef struct {
        int                owner;
        int                beats;
        int                ptr;
        logic [1:0]        sel;
        logic [DATA_W-1:0] b;
        logic              valid;
    } model_t;

    model_t m;
    logic   m_ready = 1'b0;

    function automatic int pick(logic [3:0] r, int ptr);
`ifdef MUX_ARBITER_FIXED_PRIO_EN
        for (int k = 0; k < 4; k++) if (r[k]) return k;
`else
        for (int k = 0; k < 4; k++) if (r[(ptr + k) % 4]) return (ptr + k) % 4;
`endif
        return -1;
    endfunction

    function automatic model_t release_owner(model_t s);
        model_t n = s;
`ifdef MUX_ARBITER_FIXED_PRIO_EN
        n.ptr = 0;
`else
        n.ptr = (s.owner + 1) % 4;
`endif
        n.owner = -1;
        return n;
    endfunction

    function automatic model_t model_step(model_t s, logic [3:0] r, logic [4*DATA_W-1:0] lanes);
        model_t n = s;
        n.valid = 1'b0;
        if (s.owner < 0) begin
            if (r != 4'b0000) begin
                n.owner = pick(r, s.ptr);
                n.sel   = 2'(n.owner);
                n.beats = 0;
            end
        end else if (r[s.owner]) begin
            n.b     = lanes[s.owner*DATA_W +: DATA_W];
            n.valid = 1'b1;
            n.beats = s.beats + 1;
            if (n.beats == BURST_LEN) n = release_owner(n);
        end else begin
            n = release_owner(n);
        end
        return n;
    endfunction

    function automatic logic [3:0] owner_grant(int owner);
        return (owner < 0) ? 4'b0000 : 4'(1 << owner);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m       <= '{owner: -1, beats: 0, ptr: 0, sel: 2'd0, b: '0, valid: 1'b0};
            m_ready <= 1'b1;
        end else if (m_ready) begin
            m <= model_step(m, bus.req, bus.a);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (m_ready)
            chk("cycle {valid,sel,grant,b}",
                32'({bus.valid, bus.select_line, bus.grant, bus.b}),
                32'({m.valid, m.sel, owner_grant(m.owner), m.b}));
    end

    task automatic reset_dut();
        rst_n   = 1'b0;
        bus.req = 4'b0000;
        @(negedge clk);
        rst_n   = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [DATA_W-1:0] lane0;
        logic [3:0]        flip;
        bus.req = 4'b0000;
        bus.a   = '0;
        @(negedge clk);

        // Single requester, full burst
        reset_dut();
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_sel",   32'(bus.select_line), 32'h0);
        chk("rst_valid", 32'(bus.valid), 32'h0);
        chk("rst_b",     32'(bus.b), 32'h0);
        bus.req = 4'b0001;
        bus.a   = 32'($urandom);
        bus.a[DATA_W-1:0] = 8'hA5;
        @(negedge clk);
        chk("t1_grant_c1", 32'(bus.grant), 32'h1);
        chk("t1_model_grant_c1", 32'(owner_grant(m.owner)), 32'h1);
        chk("t1_valid_c1", 32'(bus.valid), 32'h0);
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            chk($sformatf("t1_valid_c%0d", c), 32'(bus.valid), 32'h1);
            chk($sformatf("t1_b_c%0d", c), 32'(bus.b), 32'hA5);
        end
        chk("t1_grant_c5", 32'(bus.grant), 32'h0);
        chk("t1_model_grant_c5", 32'(owner_grant(m.owner)), 32'h0);
        bus.req = 4'b0000;
        @(negedge clk);
        chk("t1_grant_c6", 32'(bus.grant), 32'h0);

        // All requesters held high
        reset_dut();
        bus.req = 4'b1111;
        for (int c = 1; c <= 25; c++) begin
            bus.a = 32'($urandom);
            @(negedge clk);
`ifdef MUX_ARBITER_FIXED_PRIO_EN
            chk($sformatf("t2_grant_c%0d", c), 32'(bus.grant),
                ((c - 1) % 5 == 4) ? 32'h0 : 32'h1);
`else
            chk($sformatf("t2_grant_c%0d", c), 32'(bus.grant),
                ((c - 1) % 5 == 4) ? 32'h0 : 32'(1 << (((c - 1) / 5) % 4)));
`endif
        end

        // Requester 2 drops after two beats
        reset_dut();
        bus.req = 4'b0100;
        bus.a   = 32'($urandom);
        @(negedge clk);
        chk("t3_grant_c1", 32'(bus.grant), 32'h4);
        chk("t3_sel_c1", 32'(bus.select_line), 32'h2);
        @(negedge clk);
        chk("t3_valid_c2", 32'(bus.valid), 32'h1);
        @(negedge clk);
        chk("t3_valid_c3", 32'(bus.valid), 32'h1);
        chk("t3_grant_c3", 32'(bus.grant), 32'h4);
        bus.req = 4'b1011;
        @(negedge clk);
        chk("t3_valid_c4", 32'(bus.valid), 32'h0);
        chk("t3_grant_c4", 32'(bus.grant), 32'h0);
        @(negedge clk);
`ifdef MUX_ARBITER_FIXED_PRIO_EN
        chk("t3_grant_c5", 32'(bus.grant), 32'h1);
`else
        chk("t3_grant_c5", 32'(bus.grant), 32'h8);
        chk("t3_model_grant_c5", 32'(owner_grant(m.owner)), 32'h8);
`endif
        bus.req = 4'b0000;

        // Requester 3 arrives mid-burst of requester 1
        reset_dut();
        bus.req = 4'b0010;
        @(negedge clk);
        chk("t4_grant_c1", 32'(bus.grant), 32'h2);
        bus.req = 4'b1010;
        for (int c = 2; c <= 4; c++) begin
            bus.a = 32'($urandom);
            @(negedge clk);
            chk($sformatf("t4_grant_c%0d", c), 32'(bus.grant), 32'h2);
        end
        @(negedge clk);
        chk("t4_grant_c5", 32'(bus.grant), 32'h0);
        @(negedge clk);
`ifdef MUX_ARBITER_FIXED_PRIO_EN
        chk("t4_grant_c6", 32'(bus.grant), 32'h2);
`else
        chk("t4_grant_c6", 32'(bus.grant), 32'h8);
`endif
        bus.req = 4'b0000;

        // Reset pulse during beat 2
        reset_dut();
        bus.req = 4'b0001;
        bus.a   = 32'($urandom);
        @(negedge clk);
        chk("t5_grant_c1", 32'(bus.grant), 32'h1);
        @(negedge clk);
        chk("t5_valid_c2", 32'(bus.valid), 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_outs_c3", 32'({bus.valid, bus.select_line, bus.grant, bus.b}), 32'h0);
        rst_n = 1'b1;
        bus.a = 32'($urandom);
        lane0 = bus.a[DATA_W-1:0];
        @(negedge clk);
        chk("t5_grant_c4", 32'(bus.grant), 32'h1);
        chk("t5_valid_c4", 32'(bus.valid), 32'h0);
        @(negedge clk);
        chk("t5_valid_c5", 32'(bus.valid), 32'h1);
        chk("t5_b_c5", 32'(bus.b), 32'(lane0));
        bus.req = 4'b0000;

        // Randomized traffic; requests mostly persist so bursts can complete
        reset_dut();
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            flip  = '0;
            for (int k = 0; k < 4; k++) flip[k] = ($urandom_range(0, 5) == 0);
            bus.req = bus.req ^ flip;
            bus.a   = 32'($urandom);
            @(negedge clk);
        end
        rst_n   = 1'b1;
        bus.req = 4'b0000;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter DATA_W, default 8: width of each requester data lane and of output b.
REQ-002 Parameter BURST_LEN, default 4: max beats per grant; legal range 1..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset is synchronous and active-low.
REQ-005 req  input  4  per-requester request; req[i] high = requester i has a beat on lane i.
REQ-006 a  input  4*DATA_W  packed data lanes; lane i = a[i*DATA_W +: DATA_W].
REQ-007 grant  output  4  one-hot, or zero when idle; registered.
REQ-008 select_line  output  2  index of granted lane; registered; drives internal 4:1 mux.
REQ-009 b  output  DATA_W  registered output of the shared mux.
REQ-010 valid  output  1  registered; high when b holds an accepted beat.

Function
REQ-011 Two states SHALL exist: IDLE and BUSY.
REQ-012 IDLE: grant SHALL be 4'b0000; if any req bit is high, next cycle SHALL enter BUSY with grant one-hot on the winner and select_line = winner index.
REQ-013 Winner (round-robin build): first requester with req high, scanning upward from pointer ptr and wrapping 3->0.
REQ-014 Beat acceptance: in BUSY, a beat is accepted in any cycle where req[select_line] is high.
REQ-015 For each accepted beat in cycle t, b SHALL equal lane select_line sampled at t and valid SHALL be 1 in cycle t+1; otherwise valid SHALL be 0 and b SHALL hold its previous value.
REQ-016 A beat counter (4 bits) SHALL clear on entry to BUSY and increment per accepted beat.
REQ-017 Release: BUSY SHALL return to IDLE on the edge after the accepted beat that makes the count equal BURST_LEN, or after the first BUSY cycle in which req[select_line] is low.
REQ-018 On release, ptr SHALL become (select_line + 1) mod 4; grant SHALL drop to zero for exactly one IDLE turnaround cycle.
REQ-019 Latency: req rising in IDLE at cycle 0 -> grant at cycle 1 -> first valid at cycle 2.
REQ-020 Requests from non-granted requesters during BUSY SHALL be ignored; req changes on other lanes SHALL NOT alter grant or select_line.
REQ-021 select_line SHALL hold its last value in IDLE; grant is the authoritative ownership indicator.
REQ-022 BURST_LEN = 1: every grant SHALL last exactly one accepted beat.

Reset
REQ-023 With rst_n low at a clock edge: state = IDLE, grant = 0, select_line = 0, b = 0, valid = 0, counter = 0, ptr = 0.
REQ-024 Reset mid-burst SHALL abort the burst with no further valid beats; arbitration SHALL restart from ptr = 0.

Configuration
REQ-025 Macro MUX_ARBITER_FIXED_PRIO_EN: when defined, the winner SHALL be the lowest-index requester with req high, and ptr SHALL be unused and held at 0.
REQ-026 Without MUX_ARBITER_FIXED_PRIO_EN, the round-robin rules of REQ-013/REQ-018 SHALL apply.
REQ-027 All other behaviour SHALL be identical in both builds.

Verification
REQ-028 Reset then req=4'b0001, lane0=8'hA5 held -> grant=0001 at cycle 1; valid=1 and b=A5 on cycles 2..5; grant=0 at cycle 5 (BURST_LEN=4).
REQ-029 req=4'b1111 held continuously, round-robin build -> grants in order 0001,0010,0100,1000,0001, each 4 beats, one idle cycle between grants.
REQ-030 Same stimulus with MUX_ARBITER_FIXED_PRIO_EN -> grant always 0001, separated by one idle cycle.
REQ-031 Granted requester 2 drops req after 2 beats -> valid for exactly 2 cycles; release; next winner is searched from 3.
REQ-032 Requester 1 granted, requester 3 raises req mid-burst -> grant stays 0010 until release; then 1000.
REQ-033 rst_n low for one cycle during beat 2 of a burst -> next cycle: all outputs zero, state IDLE; req=0001 then yields a fresh grant with latency per REQ-019.
